apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

Parametrised APB memory-mapped slave with programmable wait states, transfer error reporting and optional byte strobes. It is the next-generation register-file/memory target on the team's APB bus: a fully synchronous, FSM-driven replacement for the fixed 8-bit, zero-wait slave. Configurable address width, data width and depth let one block serve every peripheral memory window.

## Interface
Parameters:
- ADDR_WIDTH, 8: width of paddr; word-addressed (one address = one DATA_WIDTH word).
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- DEPTH, 64: number of implemented words; must be ≤ 2^ADDR_WIDTH.
- WAIT_STATES, 1: wait cycles inserted before pready; legal range 0..15.

Ports:
- pclk, input, 1: bus clock; everything samples on the rising edge.
- presetn, input, 1: asynchronous active-low reset.
- pselx, input, 1: slave select.
- penable, input, 1: access phase qualifier.
- pwrite, input, 1: 1 = write, 0 = read.
- paddr, input, ADDR_WIDTH: word address.
- pwdata, input, DATA_WIDTH: write data.
- pstrb, input, DATA_WIDTH/8: byte-lane write strobes. Present only when APB_SLV_PSTRB_EN is defined.
- prdata, output, DATA_WIDTH: read data, registered.
- pready, output, 1: transfer complete.
- pslverr, output, 1: transfer error, valid only while pready=1.

## Operation
- FSM states are IDLE, WAIT and ACCESS. It uses a 4-bit wait counter cnt.
- IDLE:
  - On pselx=1 and penable=0 (setup phase), latch paddr, pwrite and pwdata (and pstrb when enabled).
  - Set err_q = (paddr ≥ DEPTH).
  - If WAIT_STATES=0, go to ACCESS. Otherwise load cnt=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - If pselx=0, abort to IDLE with no memory effect.
  - Else if cnt=0, go to ACCESS; otherwise decrement cnt.
- ACCESS:
  - pready=1 and pslverr=err_q, both decoded from state and registered flag; no combinational path from inputs.
  - Always return to IDLE next cycle.
  - If pselx=0 in ACCESS, no write occurs.
- Write: the latched word is committed at the clock edge ending ACCESS, only when pwrite=1, err_q=0 and pselx=penable=1.
- Read: prdata is loaded on the edge entering ACCESS. It holds mem[addr], or all-zeros if err_q=1. prdata holds its value outside ACCESS.
- An out-of-range write asserts pslverr and leaves memory unchanged.
- Back-to-back transfers: the cycle after ACCESS is IDLE, which accepts the next setup phase directly.
- Memory contents are not reset. Reads before the first write return X in simulation.
- Any reset assertion, including mid-transfer, aborts the transfer with no write.

## Timing
- Reset values: state=IDLE, cnt=0, err_q=0, pready=0, pslverr=0, prdata=0.
- Transfer length from setup phase (T0) to pready is WAIT_STATES+1 cycles. Total transfer is WAIT_STATES+2 cycles including setup.
- For WAIT_STATES=0: T0 setup, T1 ACCESS with pready=1.
- pready is high for exactly one cycle per transfer and never high outside ACCESS.
- Read data is valid in the same cycle pready=1.
- A read of an address written in the previous transfer returns the new data.
- Changes to penable or paddr during WAIT are ignored; the latched values are used.

## Configuration
- APB_SLV_PSTRB_EN defined:
  - The pstrb port exists.
  - For each byte lane i, mem[addr][8i+7:8i] is written only if pstrb[i]=1.
  - pstrb=0 on a write is a legal no-op that still completes with pready.
  - pstrb is ignored on reads.
- APB_SLV_PSTRB_EN undefined: the pstrb port is absent and every write updates the full word.

## Test plan
- Reset: assert presetn=0 mid-WAIT → next cycle prdata=0, pready=0, pslverr=0, state=IDLE, target word unchanged.
- WAIT_STATES=0, write 0xDEADBEEF to address 5 then read address 5 → pready high in cycle 2 of each transfer, prdata=0xDEADBEEF, pslverr=0.
- WAIT_STATES=3, read address 0 → pready low for 3 cycles after setup and high in cycle 5; exactly one pready pulse.
- DEPTH=64: write address 64 → pslverr=1 with pready; a subsequent read of address 64 → prdata=0, pslverr=1; address 0 unchanged.
- APB_SLV_PSTRB_EN: word holds 0xFFFFFFFF; write 0x11223344 with pstrb=4'b0101 → readback 0xFF22FF44.
- Abort: pselx drops during WAIT of a write to address 7 → no pready, address 7 unchanged, the next transfer completes normally.

Source files
------------

// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB bus bundle for apb_slave_mem (pstrb present only with APB_SLV_PSTRB_EN)
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();

  logic                    pselx;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_SLV_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb;
`endif
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata,
`ifdef APB_SLV_PSTRB_EN
    output pstrb,
`endif
    input  prdata, pready, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata,
`ifdef APB_SLV_PSTRB_EN
    input  pstrb,
`endif
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB word memory slave with wait states, pslverr and optional byte strobes (APB_SLV_PSTRB_EN)
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic            pclk,
  input  logic            presetn,
  apb_slave_mem_if.slave  bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          WAIT_LD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  err_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [NB-1:0]         wr_strb;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // range check on the live setup-phase address (used only in IDLE)
  logic                  setup_err;
  logic                  setup;
  logic [IDX_W-1:0]      setup_idx;
  logic [IDX_W-1:0]      addr_idx;
  logic                  commit;

  assign setup     = bus.pselx && !bus.penable;
  assign setup_err = ({1'b0, bus.paddr} >= DEPTH_L);
  assign setup_idx = bus.paddr[IDX_W-1:0];
  assign addr_idx  = addr_q[IDX_W-1:0];

  // write is committed on the edge that ends ACCESS, only for a still-selected in-range write
  assign commit = (state == ACCESS) && write_q && !err_q && bus.pselx && bus.penable;

`ifdef APB_SLV_PSTRB_EN
  logic [NB-1:0] strb_q;

  // byte strobes are captured with the rest of the setup phase
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      strb_q <= '0;
    end else if (state == IDLE && setup) begin
      strb_q <= bus.pstrb;
    end
  end

  assign wr_strb = strb_q;
`else
  assign wr_strb = '1;
`endif

  // transfer FSM: captures setup, counts wait states, presents registered pready/pslverr/prdata
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          if (setup) begin
            addr_q  <= bus.paddr;
            write_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
            err_q   <= setup_err;
            if (WAIT_STATES == 0) begin
              // no wait states: the setup edge is also the edge entering ACCESS
              state     <= ACCESS;
              pready_q  <= 1'b1;
              pslverr_q <= setup_err;
              prdata_q  <= setup_err ? '0 : mem[setup_idx];
            end else begin
              cnt   <= WAIT_LD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!bus.pselx) begin
            // master gave up: drop the transfer without touching memory
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state     <= ACCESS;
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
            prdata_q  <= err_q ? '0 : mem[addr_idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS: begin
          state     <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
      endcase
    end
  end

  // storage array is deliberately not reset; reset only blocks commits via the FSM state
  always_ff @(posedge pclk) begin
    if (commit && presetn) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_strb[i]) begin
          mem[addr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed bench for apb_slave_mem with zero and three wait states
module tb_apb_slave_mem;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if0 ();
  apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if3 ();

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .bus(if0.slave)
  );
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) dut3 (
    .pclk(pclk), .presetn(presetn), .bus(if3.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic sel, input logic en, input logic wr,
                       input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (w == 0) begin
      if0.pselx = sel; if0.penable = en; if0.pwrite = wr; if0.paddr = addr; if0.pwdata = data;
`ifdef APB_SLV_PSTRB_EN
      if0.pstrb = strb;
`endif
    end else begin
      if3.pselx = sel; if3.penable = en; if3.pwrite = wr; if3.paddr = addr; if3.pwdata = data;
`ifdef APB_SLV_PSTRB_EN
      if3.pstrb = strb;
`endif
    end
  endtask

  function automatic logic get_ready(input int w);
    return (w == 0) ? if0.pready : if3.pready;
  endfunction

  function automatic logic get_err(input int w);
    return (w == 0) ? if0.pslverr : if3.pslverr;
  endfunction

  function automatic logic [31:0] get_rdata(input int w);
    return (w == 0) ? if0.prdata : if3.prdata;
  endfunction

  // one APB transfer; rcyc is the transfer cycle (setup = 1) in which pready was seen, 0 if never
  task automatic xfer(input int w, input logic wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int abort_at, input bit wiggle,
                      output logic [31:0] rd, output logic err, output int rcyc);
    int c;
    bit done;
    rd = '0; err = 1'b0; rcyc = 0; done = 1'b0;
    drive(w, 1'b1, 1'b0, wr, addr, data, strb);
    @(posedge pclk); #1;
    c = 2;
    drive(w, 1'b1, 1'b1, wr, addr, data, strb);
    while (!done && c < 40) begin
      if (get_ready(w)) begin
        rcyc = c; rd = get_rdata(w); err = get_err(w);
        @(posedge pclk); #1;
        drive(w, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        check("pready_drop", {31'b0, get_ready(w)}, 32'd0);
        done = 1'b1;
      end else if (c == abort_at) begin
        drive(w, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        repeat (6) begin
          @(posedge pclk); #1;
          if (get_ready(w)) rcyc = -1;
        end
        done = 1'b1;
      end else begin
        if (wiggle) drive(w, 1'b1, 1'b1, wr, ~addr, data, strb);
        @(posedge pclk); #1;
        c++;
      end
    end
    if (!done) drive(w, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          rcyc;
    int          pulses;

    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    drive(3, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    repeat (3) @(posedge pclk);
    #1;
    check("rst_pready0", {31'b0, if0.pready}, 32'd0);
    check("rst_pslverr0", {31'b0, if0.pslverr}, 32'd0);
    check("rst_prdata0", if0.prdata, 32'h0);
    check("rst_pready3", {31'b0, if3.pready}, 32'd0);
    check("rst_prdata3", if3.prdata, 32'h0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    // zero wait states: write then read address 5
    xfer(0, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, err, rcyc);
    check("ws0_wr_cycle", rcyc, 32'd2);
    check("ws0_wr_err", {31'b0, err}, 32'd0);
    xfer(0, 1'b0, 8'd5, 32'h0, 4'h0, 0, 1'b0, rd, err, rcyc);
    check("ws0_rd_cycle", rcyc, 32'd2);
    check("ws0_rd_data", rd, 32'hDEADBEEF);
    check("ws0_rd_err", {31'b0, err}, 32'd0);

    // range boundary: last legal word, first illegal word
    xfer(0, 1'b1, 8'd0, 32'h0BADC0DE, 4'hF, 0, 1'b0, rd, err, rcyc);
    xfer(0, 1'b1, 8'd63, 32'h3F3F3F3F, 4'hF, 0, 1'b0, rd, err, rcyc);
    check("wr63_err", {31'b0, err}, 32'd0);
    xfer(0, 1'b1, 8'd64, 32'hCAFEF00D, 4'hF, 0, 1'b0, rd, err, rcyc);
    check("wr64_cycle", rcyc, 32'd2);
    check("wr64_err", {31'b0, err}, 32'd1);
    xfer(0, 1'b0, 8'd64, 32'h0, 4'h0, 0, 1'b0, rd, err, rcyc);
    check("rd64_data", rd, 32'h0);
    check("rd64_err", {31'b0, err}, 32'd1);
    xfer(0, 1'b0, 8'd0, 32'h0, 4'h0, 0, 1'b0, rd, err, rcyc);
    check("rd0_data", rd, 32'h0BADC0DE);
    xfer(0, 1'b0, 8'd63, 32'h0, 4'h0, 0, 1'b0, rd, err, rcyc);
    check("rd63_data", rd, 32'h3F3F3F3F);
    check("rd63_err", {31'b0, err}, 32'd0);

`ifdef APB_SLV_PSTRB_EN
    // byte strobes: partial write and empty-strobe no-op
    xfer(0, 1'b1, 8'd3, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, err, rcyc);
    xfer(0, 1'b1, 8'd3, 32'h11223344, 4'b0101, 0, 1'b0, rd, err, rcyc);
    xfer(0, 1'b0, 8'd3, 32'h0, 4'h0, 0, 1'b0, rd, err, rcyc);
    check("strb_data", rd, 32'hFF22FF44);
    xfer(0, 1'b1, 8'd3, 32'h00000000, 4'b0000, 0, 1'b0, rd, err, rcyc);
    check("strb0_cycle", rcyc, 32'd2);
    xfer(0, 1'b0, 8'd3, 32'h0, 4'h0, 0, 1'b0, rd, err, rcyc);
    check("strb0_data", rd, 32'hFF22FF44);
`else
    // without strobes every write replaces the whole word
    xfer(0, 1'b1, 8'd3, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, err, rcyc);
    xfer(0, 1'b1, 8'd3, 32'h11223344, 4'b0101, 0, 1'b0, rd, err, rcyc);
    xfer(0, 1'b0, 8'd3, 32'h0, 4'h0, 0, 1'b0, rd, err, rcyc);
    check("full_word_data", rd, 32'h11223344);
`endif

    // three wait states, paddr wiggled during WAIT must be ignored
    xfer(3, 1'b1, 8'd1, 32'h01010101, 4'hF, 0, 1'b0, rd, err, rcyc);
    check("ws3_wr_cycle", rcyc, 32'd5);
    xfer(3, 1'b0, 8'd1, 32'h0, 4'h0, 0, 1'b1, rd, err, rcyc);
    check("ws3_rd_cycle", rcyc, 32'd5);
    check("ws3_rd_data", rd, 32'h01010101);
    pulses = 0;
    repeat (4) begin
      @(posedge pclk); #1;
      if (if3.pready) pulses++;
    end
    check("ws3_single_pulse", pulses, 32'd0);

    // abort during WAIT of a write to address 7
    xfer(3, 1'b1, 8'd7, 32'h70707070, 4'hF, 0, 1'b0, rd, err, rcyc);
    xfer(3, 1'b1, 8'd7, 32'hBAD0BAD0, 4'hF, 3, 1'b0, rd, err, rcyc);
    check("abort_no_ready", rcyc, 32'd0);
    xfer(3, 1'b0, 8'd7, 32'h0, 4'h0, 0, 1'b0, rd, err, rcyc);
    check("abort_next_cycle", rcyc, 32'd5);
    check("abort_data", rd, 32'h70707070);

    // reset asserted mid-WAIT of a write to address 9
    xfer(3, 1'b1, 8'd9, 32'hA5A5A5A5, 4'hF, 0, 1'b0, rd, err, rcyc);
    xfer(3, 1'b0, 8'd9, 32'h0, 4'h0, 0, 1'b0, rd, err, rcyc);
    check("pre_rst_data", if3.prdata, 32'hA5A5A5A5);
    drive(3, 1'b1, 1'b0, 1'b1, 8'd9, 32'h12345678, 4'hF);
    @(posedge pclk); #1;
    drive(3, 1'b1, 1'b1, 1'b1, 8'd9, 32'h12345678, 4'hF);
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    check("midrst_prdata", if3.prdata, 32'h0);
    check("midrst_pready", {31'b0, if3.pready}, 32'd0);
    @(posedge pclk); #1;
    check("midrst_pslverr", {31'b0, if3.pslverr}, 32'd0);
    check("midrst_pready2", {31'b0, if3.pready}, 32'd0);
    drive(3, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(3, 1'b0, 8'd9, 32'h0, 4'h0, 0, 1'b0, rd, err, rcyc);
    check("post_rst_cycle", rcyc, 32'd5);
    check("post_rst_data", rd, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
